// File: rtl/fetch_stage_if.sv
// fetch_stage_if: stall/flush/redirect inputs, instruction-memory port and IF/ID outputs of the fetch stage
// slave  = fetch_stage view (control/memory inputs in, imem address and Decode fields out)
// master = hazard unit / Execute / memory / Decode view
interface fetch_stage_if;
  logic        iStallF;
  logic        iStallD;
  logic        iFlushD;
  logic        iPcSrcE;
  logic [31:0] iPcTargetE;
  logic [31:0] oImemAddr;
  logic [31:0] iImemData;
  logic [31:0] oInstrD;
  logic [31:0] oPcD;
  logic [31:0] oPcPlus4D;
  logic        oValidD;
  logic        oFetchFault;
  modport slave (
    input  iStallF, iStallD, iFlushD, iPcSrcE, iPcTargetE, iImemData,
    output oImemAddr, oInstrD, oPcD, oPcPlus4D, oValidD, oFetchFault
  );
  modport master (
    output iStallF, iStallD, iFlushD, iPcSrcE, iPcTargetE, iImemData,
    input  oImemAddr, oInstrD, oPcD, oPcPlus4D, oValidD, oFetchFault
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I program counter and IF/ID pipeline register
// iClk/iRst: clock, synchronous active-high reset; bus (fetch_stage_if.slave): stall/flush/redirect,
// imem address/data, registered instruction/PC/PC+4/valid to Decode, sticky fetch fault.
// FETCH_MISALIGN_CHECK_EN: align misaligned redirect targets and raise the sticky oFetchFault flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          iClk,
  input logic          iRst,
  fetch_stage_if.slave bus
);
  logic [31:0] pc_q, pc_d, pc_plus4, target;
  logic [31:0] instr_q, instr_d, pc_dec_q, pc_dec_d, pc_plus4_dec_q, pc_plus4_dec_d;
  logic        valid_q, valid_d, bubble;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fault_q, fault_d;
  assign target = {bus.iPcTargetE[31:2], 2'b00};
  always_comb fault_d = fault_q | (bus.iPcSrcE & |bus.iPcTargetE[1:0]);
  always_ff @(posedge iClk)
    if (iRst) fault_q <= 1'b0;
    else fault_q <= fault_d;
  assign bus.oFetchFault = fault_q;
`else
  assign target = bus.iPcTargetE;
  assign bus.oFetchFault = 1'b0;
`endif
  // a taken redirect squashes the wrong-path word even without iFlushD
  always_comb begin
    pc_plus4       = pc_q + 32'd4;
    bubble         = bus.iFlushD | bus.iPcSrcE;
    pc_d           = bus.iPcSrcE ? target : bus.iStallF ? pc_q : pc_plus4;
    instr_d        = bubble ? NOP_INSTR : bus.iStallD ? instr_q : bus.iImemData;
    pc_dec_d       = bubble ? 32'd0 : bus.iStallD ? pc_dec_q : pc_q;
    pc_plus4_dec_d = bubble ? 32'd0 : bus.iStallD ? pc_plus4_dec_q : pc_plus4;
    valid_d        = bubble ? 1'b0 : bus.iStallD ? valid_q : 1'b1;
  end
  always_ff @(posedge iClk)
    if (iRst) begin
      pc_q           <= RESET_PC;
      instr_q        <= NOP_INSTR;
      pc_dec_q       <= 32'd0;
      pc_plus4_dec_q <= 32'd0;
      valid_q        <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      pc_dec_q       <= pc_dec_d;
      pc_plus4_dec_q <= pc_plus4_dec_d;
      valid_q        <= valid_d;
    end
  assign bus.oImemAddr = pc_q;
  assign bus.oInstrD   = instr_q;
  assign bus.oPcD      = pc_dec_q;
  assign bus.oPcPlus4D = pc_plus4_dec_q;
  assign bus.oValidD   = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  fetch_stage_if bus();
  fetch_stage dut (.iClk(clk), .iRst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.iImemData = 32'h1000_0000 | bus.oImemAddr;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] pc4, input logic v);
    chk({tag, "_instr"}, bus.oInstrD, instr);
    chk({tag, "_pcd"}, bus.oPcD, pc);
    chk({tag, "_pc4d"}, bus.oPcPlus4D, pc4);
    chk({tag, "_valid"}, {31'd0, bus.oValidD}, {31'd0, v});
  endtask
  initial begin
    logic [31:0] mis_pc;
    logic        mis_fault;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_pc = 32'h0000_0100;
    mis_fault = 1'b1;
`else
    mis_pc = 32'h0000_0102;
    mis_fault = 1'b0;
`endif
    bus.iStallF = 0; bus.iStallD = 0; bus.iFlushD = 0; bus.iPcSrcE = 0; bus.iPcTargetE = 0;
    step();
    chk("rst_addr", bus.oImemAddr, 32'h0);
    chk("rst_fault", {31'd0, bus.oFetchFault}, 32'd0);
    chk_d("rst", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
    rst = 0;
    step();
    chk("run1_addr", bus.oImemAddr, 32'h4);
    chk_d("run1", 32'h1000_0000, 32'h0, 32'h4, 1'b1);
    step();
    chk("run2_addr", bus.oImemAddr, 32'h8);
    chk_d("run2", 32'h1000_0004, 32'h4, 32'h8, 1'b1);
    bus.iStallF = 1; bus.iStallD = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", bus.oImemAddr, 32'h8);
      chk_d("stall", 32'h1000_0004, 32'h4, 32'h8, 1'b1);
    end
    bus.iStallF = 0; bus.iStallD = 0;
    step();
    chk("rel_addr", bus.oImemAddr, 32'hC);
    chk_d("rel", 32'h1000_0008, 32'h8, 32'hC, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("walk_addr", bus.oImemAddr, 32'h10 + 32'(i) * 4);
    end
    chk_d("walk", 32'h1000_001C, 32'h1C, 32'h20, 1'b1);
    bus.iPcSrcE = 1; bus.iPcTargetE = 32'h100; bus.iStallF = 1;
    step();
    chk("redir_addr", bus.oImemAddr, 32'h100);
    chk_d("redir", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
    bus.iPcSrcE = 0; bus.iStallF = 0;
    step();
    chk("tgt_addr", bus.oImemAddr, 32'h104);
    chk_d("tgt", 32'h1000_0100, 32'h100, 32'h104, 1'b1);
    bus.iFlushD = 1; bus.iStallD = 1;
    step();
    chk_d("flush", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
    bus.iFlushD = 0; bus.iStallD = 0;
    bus.iPcSrcE = 1; bus.iPcTargetE = 32'hFFFF_FFFC;
    step();
    chk("top_addr", bus.oImemAddr, 32'hFFFF_FFFC);
    bus.iPcSrcE = 0;
    step();
    chk("wrap_addr", bus.oImemAddr, 32'h0);
    chk_d("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk("wrap_fault", {31'd0, bus.oFetchFault}, 32'd0);
    bus.iPcSrcE = 1; bus.iPcTargetE = 32'h102;
    step();
    chk("mis_addr", bus.oImemAddr, mis_pc);
    chk("mis_fault", {31'd0, bus.oFetchFault}, {31'd0, mis_fault});
    bus.iPcTargetE = 32'h200;
    step();
    chk("align_addr", bus.oImemAddr, 32'h200);
    bus.iPcSrcE = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_fault", {31'd0, bus.oFetchFault}, {31'd0, mis_fault});
    end
    rst = 1; bus.iPcSrcE = 1; bus.iPcTargetE = 32'h300; bus.iStallF = 1; bus.iStallD = 1;
    step();
    chk("mrst_addr", bus.oImemAddr, 32'h0);
    chk("mrst_fault", {31'd0, bus.oFetchFault}, 32'd0);
    chk_d("mrst", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
